// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: divider FSM states and the divide-by-zero quotient value.
package alu_pkg;
  typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_RUN = 2'd1, DIV_DONE = 2'd2} div_state_t;

  // Wide all-ones; users slice off the bits they need.
  localparam logic [63:0] DIV_Q_ON_ZERO = '1;
endpackage

// File: rtl/seq_div_16bit_if.sv
// Start/busy/done handshake plus operand and result buses of the sequential divider.
interface seq_div_16bit_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div0;

  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div0);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div0);
endinterface

// File: rtl/seq_div_16bit_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module seq_div_16bit_step #(parameter int WIDTH = 16) (
  input  logic [WIDTH-1:0] rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             qbit
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   b_inv;
  logic [WIDTH+1:0] sum;

  // a - b as a + ~b + 1; carry-out set means no borrow.
  assign shifted  = {rem, msb};
  assign b_inv    = ~{1'b0, divisor};
  assign sum      = {1'b0, shifted} + {1'b0, b_inv} + (WIDTH+2)'(1);
  assign qbit     = sum[WIDTH+1];
  assign next_rem = qbit ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/seq_div_16bit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
module seq_div_16bit
  import alu_pkg::*;
#(parameter int WIDTH = 16) (
  input  logic             clk,
  input  logic             rst_n,
  seq_div_16bit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] next_rem;
  logic             qbit;

  seq_div_16bit_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .msb      (quo_q[WIDTH-1]),
    .divisor  (dvs_q),
    .next_rem (next_rem),
    .qbit     (qbit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div0_d      = div0_q;
    unique case (state_q)
      DIV_IDLE: if (bus.start) begin
        if (bus.divisor != '0) begin
          dvs_d   = bus.divisor;
          rem_d   = '0;
          quo_d   = bus.dividend;
          cnt_d   = CW'(WIDTH-1);
          div0_d  = 1'b0;
          state_d = DIV_RUN;
        end else begin
          // Zero divisor skips the iteration loop entirely.
          quotient_d  = DIV_Q_ON_ZERO[WIDTH-1:0];
          remainder_d = bus.dividend;
          div0_d      = 1'b1;
          state_d     = DIV_DONE;
        end
      end
      DIV_RUN: begin
        rem_d = next_rem;
        quo_d = {quo_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quotient_d  = {quo_q[WIDTH-2:0], qbit};
          remainder_d = next_rem;
          state_d     = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div0_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div0_q      <= div0_d;
    end
  end

  assign bus.busy      = (state_q == DIV_RUN);
  assign bus.done      = (state_q == DIV_DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div0      = div0_q;
endmodule

// File: tb/tb_seq_div_16bit.sv
// Directed bench for seq_div_16bit: vector table plus ignore-start and mid-run reset sequences.
module tb_seq_div_16bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  seq_div_16bit_if #(.WIDTH(16)) bus();

  seq_div_16bit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        d0;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Runs one division; lat is the cycle index of done counting the cycle right after the start edge as 1.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, input int repulse_at,
                         input bit start_in_done,
                         output logic [15:0] q, output logic [15:0] r, output logic d0,
                         output int lat, output bit busy_seen, output bit busy_at_done,
                         output logic done_after, output logic [15:0] q_after,
                         output logic busy_after2);
    int e;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = 16'($urandom); bus.divisor = 16'($urandom);
    e = 0; busy_seen = 1'b0;
    while (!bus.done && e < 40) begin
      busy_seen |= bus.busy;
      if (e == repulse_at) begin
        bus.start = 1'b1; bus.dividend = 16'd50; bus.divisor = 16'd5;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      e++;
    end
    lat = e + 1;
    q = bus.quotient; r = bus.remainder; d0 = bus.div0; busy_at_done = bus.busy;
    if (start_in_done) begin
      bus.start = 1'b1; bus.dividend = 16'd50; bus.divisor = 16'd5;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_after = bus.done; q_after = bus.quotient;
    @(posedge clk); #1;
    busy_after2 = bus.busy;
  endtask

  vec_t vecs[11];

  initial begin
    logic [15:0] q, r, q_after;
    logic d0, done_after, busy_after2;
    int lat;
    bit busy_seen, busy_at_done;

    vecs[0]  = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 17};
    vecs[1]  = '{16'hFFFF, 16'd1,    16'hFFFF, 16'd0,    1'b0, 17};
    vecs[2]  = '{16'hFFFF, 16'hFFFF, 16'd1,    16'd0,    1'b0, 17};
    vecs[3]  = '{16'h8000, 16'd3,    16'h2AAA, 16'd2,    1'b0, 17};
    vecs[4]  = '{16'd3,    16'd5,    16'd0,    16'd3,    1'b0, 17};
    vecs[5]  = '{16'd0,    16'd9,    16'd0,    16'd0,    1'b0, 17};
    vecs[6]  = '{16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1, 1};
    vecs[7]  = '{16'd10,   16'd3,    16'd3,    16'd1,    1'b0, 17};
    vecs[8]  = '{16'hFFFF, 16'h8001, 16'd1,    16'h7FFE, 1'b0, 17};
    vecs[9]  = '{16'd1000, 16'd10,   16'd100,  16'd0,    1'b0, 17};
    vecs[10] = '{16'hFFFE, 16'hFFFF, 16'd0,    16'hFFFE, 1'b0, 17};

    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_q", {16'd0, bus.quotient}, 32'd0);
    check("rst_r", {16'd0, bus.remainder}, 32'd0);
    check("rst_div0", {31'd0, bus.div0}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_div(vecs[i].a, vecs[i].b, -1, 1'b0, q, r, d0, lat, busy_seen, busy_at_done,
              done_after, q_after, busy_after2);
      check($sformatf("v%0d_q", i), {16'd0, q}, {16'd0, vecs[i].q});
      check($sformatf("v%0d_r", i), {16'd0, r}, {16'd0, vecs[i].r});
      check($sformatf("v%0d_div0", i), {31'd0, d0}, {31'd0, vecs[i].d0});
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_busy_seen", i), {31'd0, busy_seen}, {31'd0, !vecs[i].d0});
      check($sformatf("v%0d_busy_at_done", i), {31'd0, busy_at_done}, 32'd0);
      check($sformatf("v%0d_done_pulse", i), {31'd0, done_after}, 32'd0);
      check($sformatf("v%0d_q_held", i), {16'd0, q_after}, {16'd0, vecs[i].q});
    end

    // Start pulses while busy and in the done cycle must both be dropped.
    run_div(16'd100, 16'd7, 4, 1'b1, q, r, d0, lat, busy_seen, busy_at_done,
            done_after, q_after, busy_after2);
    check("repulse_q", {16'd0, q}, 32'd14);
    check("repulse_r", {16'd0, r}, 32'd2);
    check("repulse_lat", lat, 17);
    check("start_in_done_pulse", {31'd0, done_after}, 32'd0);
    check("start_in_done_q", {16'd0, q_after}, 32'd14);
    check("start_in_done_busy", {31'd0, busy_after2}, 32'd0);
    check("start_in_done_r", {16'd0, bus.remainder}, 32'd2);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 16'd100; bus.divisor = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_q", {16'd0, bus.quotient}, 32'd0);
    check("arst_r", {16'd0, bus.remainder}, 32'd0);
    check("arst_div0", {31'd0, bus.div0}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    begin
      bit saw = 1'b0;
      for (int k = 0; k < 24; k++) begin
        @(posedge clk); #1;
        saw |= bus.done | bus.busy;
      end
      check("no_done_after_rst", {31'd0, saw}, 32'd0);
    end
    run_div(16'd9, 16'd2, -1, 1'b0, q, r, d0, lat, busy_seen, busy_at_done,
            done_after, q_after, busy_after2);
    check("post_rst_q", {16'd0, q}, 32'd4);
    check("post_rst_r", {16'd0, r}, 32'd1);
    check("post_rst_lat", lat, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
